// File: rtl/clk_div_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_bank_if
//  Purpose  : Control and status bundle for the clk_div_bank clock divider.
//             The controller (master) drives the per-channel enables, the
//             packed divisor fields and the shared load/sync strobes. The
//             divider (slave) returns the divided clocks, period ticks and
//             invalid-divisor flags.
//  Signals  : en   [NCH]     per-channel enable
//             div  [NCH*DW]  requested divisors, channel i at [i*DW +: DW]
//             load [1]       capture all div fields into pending registers
//             sync [1]       restart all enabled channels at phase 0
//             bclk [NCH]     divided clocks (registered)
//             tick [NCH]     first-high-cycle pulse of each bclk period
//             err  [NCH]     active divisor is 0 or 1
//  Revision : 1.0  initial release
// ============================================================================
interface clk_div_bank_if #(
    parameter int NCH = 4,
    parameter int DW  = 8
);
    logic [NCH-1:0]    en;
    logic [NCH*DW-1:0] div;
    logic              load;
    logic              sync;
    logic [NCH-1:0]    bclk;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    err;

    modport master (
        output en, div, load, sync,
        input  bclk, tick, err
    );

    modport slave (
        input  en, div, load, sync,
        output bclk, tick, err
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_bank
//  Purpose  : Bank of NCH independent integer clock dividers running off one
//             master clock. Each channel keeps an active divisor, a pending
//             divisor with a valid bit, and a phase counter. New divisors are
//             only adopted on a period boundary (or on sync / channel start),
//             so no period is ever truncated or stretched.
//  Ports    : mclk  master clock, rising edge
//             rst   asynchronous active-high reset
//             bus   clk_div_bank_if.slave (en, div, load, sync -> bclk,
//                   tick, err)
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_bank #(
    parameter int NCH = 4,
    parameter int DW  = 8
) (
    input  wire logic         mclk,
    input  wire logic         rst,
    clk_div_bank_if.slave     bus
);

    localparam logic [DW-1:0] c_RST_DIV = DW'(2);

    logic [NCH-1:0] w_bclk;
    logic [NCH-1:0] w_tick;
    logic [NCH-1:0] w_err;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // Registered state
        logic [DW-1:0] a_q, a_d;      // active divisor
        logic [DW-1:0] p_q, p_d;      // pending divisor
        logic          pv_q, pv_d;    // pending valid
        logic [DW-1:0] c_q, c_d;      // phase counter
        logic          run_q, run_d;  // channel was enabled last cycle
        logic          bclk_q, bclk_d;
        logic          tick_q, tick_d;
        logic          err_q, err_d;

        // Combinational helpers
        logic [DW-1:0] w_div;
        logic [DW-1:0] w_src_p;
        logic [DW-1:0] w_high;
        logic          w_src_pv;
        logic          w_bad;
        logic          w_wrap;
        logic          w_adopt;
        logic          w_sync_load;

        always_comb begin
            w_div       = bus.div[i*DW +: DW];
            w_bad       = (a_q < DW'(2));
            // An invalid divisor has no real period, so every cycle counts as
            // a boundary; this lets a later valid load take effect promptly.
            w_wrap      = w_bad || (c_q == a_q - DW'(1));
            // A same-cycle load+sync bypasses the pending register so the
            // sync applies the freshly requested divisor.
            w_sync_load = bus.sync && bus.load;
            w_src_p     = w_sync_load ? w_div : p_q;
            w_src_pv    = w_sync_load || pv_q;
            // Adoption points: sync, first enabled cycle after idle, or the
            // natural end of the current period.
            w_adopt     = bus.en[i] && (bus.sync || !run_q || w_wrap);

            p_d = bus.load ? w_div : p_q;

            pv_d = pv_q;
            if (w_adopt) begin
                pv_d = 1'b0;
            end
            // A plain load that coincides with a boundary stays pending; it
            // is applied at the following boundary.
            if (bus.load && !(bus.sync && w_adopt)) begin
                pv_d = 1'b1;
            end

            a_d = a_q;
            if (w_adopt && w_src_pv) begin
                a_d = w_src_p;
            end

            run_d = bus.en[i];

            c_d = '0;
            if (bus.en[i] && !w_adopt) begin
                c_d = c_q + DW'(1);
            end

            // High for ceil(A/2) cycles at the start of each period.
            w_high = a_d - (a_d >> 1);
            bclk_d = bus.en[i] && (a_d >= DW'(2)) && (c_d < w_high);
            tick_d = bclk_d && (c_d == '0);
            err_d  = (a_d < DW'(2));
        end

        always_ff @(posedge mclk or posedge rst) begin
            if (rst) begin
                a_q    <= c_RST_DIV;
                p_q    <= c_RST_DIV;
                pv_q   <= 1'b0;
                c_q    <= '0;
                run_q  <= 1'b0;
                bclk_q <= 1'b0;
                tick_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                a_q    <= a_d;
                p_q    <= p_d;
                pv_q   <= pv_d;
                c_q    <= c_d;
                run_q  <= run_d;
                bclk_q <= bclk_d;
                tick_q <= tick_d;
                err_q  <= err_d;
            end
        end

        assign w_bclk[i] = bclk_q;
        assign w_tick[i] = tick_q;
        assign w_err[i]  = err_q;
    end

    assign bus.bclk = w_bclk;
    assign bus.tick = w_tick;
    assign bus.err  = w_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_bank
//  Purpose  : Directed self-checking bench for clk_div_bank (NCH=4, DW=8).
//             Each task drives one scenario and compares outputs sampled 1
//             time unit after the rising mclk edge against hand-derived
//             values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_bank;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int PER = 10;

    logic mclk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    clk_div_bank_if #(.NCH(NCH), .DW(DW)) bus ();

    clk_div_bank #(.NCH(NCH), .DW(DW)) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial mclk = 1'b0;
    always #(PER/2) mclk = ~mclk;

    task automatic step;
        @(posedge mclk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst      = 1'b1;
        bus.en   = '0;
        bus.div  = '0;
        bus.load = 1'b0;
        bus.sync = 1'b0;
        repeat (2) @(posedge mclk);
        #1;
        checks++; if (bus.bclk !== 4'b0000) begin errors++; $display("FAIL reset_bclk: got %b want 0000", bus.bclk); end
        checks++; if (bus.tick !== 4'b0000) begin errors++; $display("FAIL reset_tick: got %b want 0000", bus.tick); end
        checks++; if (bus.err  !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b want 0000", bus.err); end
        // Enables asserted while still in reset must not start anything.
        bus.en = 4'b1111;
        step();
        checks++; if (bus.bclk !== 4'b0000) begin errors++; $display("FAIL reset_hold_bclk: got %b want 0000", bus.bclk); end
        rst = 1'b0;
        // Reset divisor is 2: first cycle high with tick, second low.
        step();
        checks++; if (bus.bclk !== 4'b1111) begin errors++; $display("FAIL reset_start_bclk: got %b want 1111", bus.bclk); end
        checks++; if (bus.tick !== 4'b1111) begin errors++; $display("FAIL reset_start_tick: got %b want 1111", bus.tick); end
        step();
        checks++; if (bus.bclk !== 4'b0000) begin errors++; $display("FAIL reset_div2_low: got %b want 0000", bus.bclk); end
    endtask

    // ------------------------------------------------------------------
    // Divisors 2/3/4/5 on channels 0..3, aligned by sync; LCM is 60.
    task automatic test_phase_align;
        logic [3:0] exp_b;
        logic [3:0] exp_t;
        int         a;
        int         ph;
        bus.div  = {8'd5, 8'd4, 8'd3, 8'd2};
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        for (int k = 0; k <= 60; k++) begin
            for (int i = 0; i < NCH; i++) begin
                a  = i + 2;
                ph = k % a;
                exp_b[i] = (ph < (a - a / 2));
                exp_t[i] = (ph == 0);
            end
            checks++; if (bus.bclk !== exp_b) begin errors++; $display("FAIL align_bclk k=%0d: got %b want %b", k, bus.bclk, exp_b); end
            checks++; if (bus.tick !== exp_t) begin errors++; $display("FAIL align_tick k=%0d: got %b want %b", k, bus.tick, exp_t); end
            if (k < 60) step();
        end
    endtask

    // ------------------------------------------------------------------
    // Channel 0 at divisor 4; load 6 while C=1. Expected from C=2 onward:
    // 0,0 (tail of period 4) then 1,1,1,0,0,0 (period 6) then 1.
    task automatic test_reload_boundary;
        logic [8:0] pat_b;
        logic [8:0] pat_t;
        pat_b = 9'b100011100;
        pat_t = 9'b100000100;
        bus.div  = {8'd5, 8'd4, 8'd3, 8'd4};
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        checks++; if (bus.tick[0] !== 1'b1) begin errors++; $display("FAIL reload_start_tick: got %b want 1", bus.tick[0]); end
        step();                       // C0 = 1
        bus.div  = {8'd5, 8'd4, 8'd3, 8'd6};
        bus.load = 1'b1;
        step();                       // C0 = 2, pending 6
        bus.load = 1'b0;
        for (int j = 0; j < 9; j++) begin
            checks++; if (bus.bclk[0] !== pat_b[j]) begin errors++; $display("FAIL reload_bclk j=%0d: got %b want %b", j, bus.bclk[0], pat_b[j]); end
            checks++; if (bus.tick[0] !== pat_t[j]) begin errors++; $display("FAIL reload_tick j=%0d: got %b want %b", j, bus.tick[0], pat_t[j]); end
            if (j < 8) step();
        end
        checks++; if (bus.err[0] !== 1'b0) begin errors++; $display("FAIL reload_err: got %b want 0", bus.err[0]); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_err_divisor;
        bus.div  = {8'd5, 8'd4, 8'd1, 8'd6};
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (4) step();
        checks++; if (bus.err[1] !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", bus.err[1]); end
        for (int j = 0; j < 5; j++) begin
            checks++; if (bus.bclk[1] !== 1'b0 || bus.tick[1] !== 1'b0) begin errors++; $display("FAIL err_hold j=%0d: got bclk=%b tick=%b want 0 0", j, bus.bclk[1], bus.tick[1]); end
            step();
        end
        bus.div  = {8'd5, 8'd4, 8'd3, 8'd6};
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        checks++; if (bus.err[1] !== 1'b1) begin errors++; $display("FAIL err_pending: got %b want 1", bus.err[1]); end
        step();
        checks++; if (bus.err[1] !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus.err[1]); end
        checks++; if (bus.bclk[1] !== 1'b1 || bus.tick[1] !== 1'b1) begin errors++; $display("FAIL err_restart: got bclk=%b tick=%b want 1 1", bus.bclk[1], bus.tick[1]); end
        step();
        checks++; if (bus.bclk[1] !== 1'b1 || bus.tick[1] !== 1'b0) begin errors++; $display("FAIL div3_c1: got bclk=%b tick=%b want 1 0", bus.bclk[1], bus.tick[1]); end
        step();
        checks++; if (bus.bclk[1] !== 1'b0) begin errors++; $display("FAIL div3_c2: got %b want 0", bus.bclk[1]); end
        step();
        checks++; if (bus.bclk[1] !== 1'b1 || bus.tick[1] !== 1'b1) begin errors++; $display("FAIL div3_wrap: got bclk=%b tick=%b want 1 1", bus.bclk[1], bus.tick[1]); end
    endtask

    // ------------------------------------------------------------------
    // Channel 2 idle for 10 cycles; a sync mid-way must skip it.
    task automatic test_idle_and_sync;
        bus.en = 4'b1011;
        step();
        for (int j = 0; j < 10; j++) begin
            checks++; if (bus.bclk[2] !== 1'b0 || bus.tick[2] !== 1'b0) begin errors++; $display("FAIL idle j=%0d: got bclk=%b tick=%b want 0 0", j, bus.bclk[2], bus.tick[2]); end
            if (j == 5) begin
                checks++; if (bus.bclk !== 4'b1011) begin errors++; $display("FAIL idle_sync_bclk: got %b want 1011", bus.bclk); end
                checks++; if (bus.tick !== 4'b1011) begin errors++; $display("FAIL idle_sync_tick: got %b want 1011", bus.tick); end
            end
            bus.sync = (j == 4);
            if (j < 9) step();
        end
        bus.sync = 1'b0;
        bus.en   = 4'b1111;
        step();
        checks++; if (bus.bclk[2] !== 1'b1 || bus.tick[2] !== 1'b1) begin errors++; $display("FAIL wake: got bclk=%b tick=%b want 1 1", bus.bclk[2], bus.tick[2]); end
        step();
        checks++; if (bus.bclk[2] !== 1'b1 || bus.tick[2] !== 1'b0) begin errors++; $display("FAIL wake_c1: got bclk=%b tick=%b want 1 0", bus.bclk[2], bus.tick[2]); end
        step();
        checks++; if (bus.bclk[2] !== 1'b0) begin errors++; $display("FAIL wake_c2: got %b want 0", bus.bclk[2]); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset;
        int n;
        n = 0;
        while (bus.bclk[3] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++; if (bus.bclk[3] !== 1'b1) begin errors++; $display("FAIL arst_wait: got bclk3=%b want 1 within 20 cycles", bus.bclk[3]); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.bclk !== 4'b0000) begin errors++; $display("FAIL arst_immediate: got %b want 0000", bus.bclk); end
        repeat (3) @(posedge mclk);
        #1;
        checks++; if (bus.bclk !== 4'b0000 || bus.tick !== 4'b0000 || bus.err !== 4'b0000) begin errors++; $display("FAIL arst_hold: got bclk=%b tick=%b err=%b want 0", bus.bclk, bus.tick, bus.err); end
        rst = 1'b0;
        step();
        checks++; if (bus.bclk !== 4'b1111 || bus.tick !== 4'b1111) begin errors++; $display("FAIL arst_resume: got bclk=%b tick=%b want 1111 1111", bus.bclk, bus.tick); end
        step();
        checks++; if (bus.bclk !== 4'b0000 || bus.tick !== 4'b0000) begin errors++; $display("FAIL arst_div2_low: got bclk=%b tick=%b want 0", bus.bclk, bus.tick); end
        step();
        checks++; if (bus.bclk !== 4'b1111 || bus.tick !== 4'b1111) begin errors++; $display("FAIL arst_div2_high: got bclk=%b tick=%b want 1111 1111", bus.bclk, bus.tick); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_sync_same;
        time        t_prev [NCH];
        int         nticks [NCH];
        logic [3:0] exp_b;
        logic [3:0] exp_t;
        for (int i = 0; i < NCH; i++) begin
            t_prev[i] = 0;
            nticks[i] = 0;
        end
        bus.div  = {8'd7, 8'd7, 8'd7, 8'd7};
        bus.load = 1'b1;
        bus.sync = 1'b1;
        step();
        bus.load = 1'b0;
        bus.sync = 1'b0;
        for (int k = 0; k <= 21; k++) begin
            exp_b = ((k % 7) < 4) ? 4'b1111 : 4'b0000;
            exp_t = ((k % 7) == 0) ? 4'b1111 : 4'b0000;
            checks++; if (bus.bclk !== exp_b) begin errors++; $display("FAIL ls_bclk k=%0d: got %b want %b", k, bus.bclk, exp_b); end
            checks++; if (bus.tick !== exp_t) begin errors++; $display("FAIL ls_tick k=%0d: got %b want %b", k, bus.tick, exp_t); end
            for (int i = 0; i < NCH; i++) begin
                if (bus.tick[i] === 1'b1) begin
                    if (nticks[i] > 0) begin
                        checks++; if (($time - t_prev[i]) !== time'(7 * PER)) begin errors++; $display("FAIL ls_period ch%0d: got %0t want %0d", i, $time - t_prev[i], 7 * PER); end
                    end
                    t_prev[i] = $time;
                    nticks[i]++;
                end
            end
            if (k < 21) step();
        end
        for (int i = 0; i < NCH; i++) begin
            checks++; if (nticks[i] !== 4) begin errors++; $display("FAIL ls_tick_count ch%0d: got %0d want 4", i, nticks[i]); end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_phase_align();
        test_reload_boundary();
        test_err_divisor();
        test_idle_and_sync();
        test_async_reset();
        test_load_sync_same();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter DW, default 8, divisor width in bits (2..16).
REQ-003 mclk  input  1  master clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  NCH  per-channel enable; bit i gates channel i.
REQ-006 div  input  NCH*DW  requested divisor per channel; channel i uses bits [i*DW +: DW].
REQ-007 load  input  1  one-cycle request: sample all div fields into the pending registers.
REQ-008 sync  input  1  one-cycle request: restart every enabled channel at phase 0 together.
REQ-009 bclk  output  NCH  divided clocks, registered, glitch-free.
REQ-010 tick  output  NCH  one-cycle pulse marking the first high cycle of each bclk period.
REQ-011 err  output  NCH  divisor-invalid flag per channel.

Function
REQ-012 Each channel SHALL hold an active divisor A, a pending divisor P, a pending-valid bit PV, and a phase counter C of width DW.
REQ-013 On load, P SHALL capture div and PV SHALL set for every channel in the same cycle.
REQ-014 A SHALL take P only at a period boundary, when C = A-1 or the channel is idle; PV then clears. This guarantees no truncated or stretched period.
REQ-015 A second load before the boundary SHALL overwrite P; only the latest value is applied.
REQ-016 For A >= 2, C SHALL count 0..A-1 and then wrap to 0; the period is exactly A mclk cycles.
REQ-017 bclk SHALL be 1 when C < A-(A>>1) and 0 otherwise: high for ceil(A/2) cycles, low for floor(A/2) cycles.
REQ-018 tick SHALL be 1 exactly in the cycles where bclk is high and C = 0.
REQ-019 For A = 0 or A = 1, the channel SHALL hold bclk = 0, tick = 0, C = 0 and err = 1. err SHALL clear when a valid A (>= 2) is adopted.
REQ-020 Idle channel (en = 0): C = 0, bclk = 0, tick = 0. On a later en rise, the channel adopts P if PV = 1, and bclk/tick SHALL go to 1 in the first cycle with en = 1.
REQ-021 When en falls, the channel SHALL enter idle at the next posedge. Software gates only when bclk is low; the block does not delay the stop.
REQ-022 On sync, every enabled channel SHALL adopt P if PV = 1, force C = 0, and in the next cycle present bclk = 1 and tick = 1. Rising edges of all enabled channels therefore coincide.
REQ-023 sync and load in the same cycle: the new div values SHALL be captured and applied immediately by the sync.
REQ-024 sync SHALL take priority over the natural wrap. Disabled channels SHALL ignore sync.
REQ-025 Channels are fully independent except for the shared load and sync signals.
REQ-026 All outputs SHALL be direct register outputs, with no combinational path from inputs to outputs.

Reset
REQ-027 While rst = 1: bclk = 0, tick = 0, err = 0, C = 0, A = 2, P = 2, PV = 0, regardless of mclk.
REQ-028 Assertion of rst mid-period SHALL zero bclk immediately (asynchronously). After deassertion, an enabled channel restarts at C = 0 on the first posedge.

Verification
REQ-029 NCH=4, DW=8; load div = {2,3,4,5}, sync, all en = 1 -> bclk periods of 2/3/4/5 cycles, high times 1/2/2/3, all four rising edges coincide on the cycle after sync, and coincide again every 60 cycles.
REQ-030 Channel 0 at A = 4; load div0 = 6 at C = 1 -> the current period completes at 4 cycles and the next period is 6 (high 3, low 3); no period of length 5.
REQ-031 load div1 = 1 -> after the boundary, err[1] = 1 and bclk[1] is held 0; then load div1 = 3 -> err[1] clears at the boundary and the period is 3.
REQ-032 en[2] low for 10 cycles, then high -> bclk[2] = 0 while idle; tick[2] = 1 and bclk[2] = 1 on the first enabled cycle.
REQ-033 Assert rst for 3 cycles mid-period with channel 3 high -> bclk[3] = 0 immediately; after release, period 2 (reset divisor) resumes from C = 0.
REQ-034 Same-cycle load and sync with div = {7,7,7,7} -> all channels show period 7 starting the next cycle, with tick on every channel simultaneously; the bench measures periods and phases in real time.
